// File: rtl/axi_lite_param_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS registers, the top NUM_RO of which are
// read-only status inputs. Byte strobes, per-register write pulses, SLVERR decode.
module axi_lite_param_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int NUM_RO     = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                             s00_axi_aclk,
  input  logic                             s00_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]            s00_axi_awaddr,
  input  logic [2:0]                       s00_axi_awprot,
  input  logic                             s00_axi_awvalid,
  output logic                             s00_axi_awready,
  input  logic [DATA_WIDTH-1:0]            s00_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]          s00_axi_wstrb,
  input  logic                             s00_axi_wvalid,
  output logic                             s00_axi_wready,
  output logic [1:0]                       s00_axi_bresp,
  output logic                             s00_axi_bvalid,
  input  logic                             s00_axi_bready,
  input  logic [ADDR_WIDTH-1:0]            s00_axi_araddr,
  input  logic [2:0]                       s00_axi_arprot,
  input  logic                             s00_axi_arvalid,
  output logic                             s00_axi_arready,
  output logic [DATA_WIDTH-1:0]            s00_axi_rdata,
  output logic [1:0]                       s00_axi_rresp,
  output logic                             s00_axi_rvalid,
  input  logic                             s00_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_out,
  output logic [NUM_REGS-1:0]              reg_wr_pulse,
  input  logic [NUM_RO*DATA_WIDTH-1:0]     status_in
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int LSB      = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - LSB;
  localparam int RIDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int RW_COUNT = NUM_REGS - NUM_RO;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;

  wstate_e                 wstate_q, wstate_d;
  logic [IDX_W-1:0]        aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  logic                    rvalid_q, rvalid_d;
  logic                    arready_q, arready_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   rd_word [NUM_REGS];

  logic                    aw_hs, w_hs, ar_hs;
  logic                    wr_fire, wr_ok;
  logic [IDX_W-1:0]        wr_idx;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [STRB_W-1:0]       wr_strb;
  logic [IDX_W-1:0]        rd_idx;
  logic                    rd_in_range;
  logic                    unused_inputs;

  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[LSB-1:0], s00_axi_araddr[LSB-1:0]};

  assign aw_hs = s00_axi_awvalid & awready_q;
  assign w_hs  = s00_axi_wvalid & wready_q;
  assign ar_hs = s00_axi_arvalid & arready_q;

  // Pick the write address/data from the live bus or the earlier captured half.
  always_comb begin
    wr_fire = 1'b0;
    wr_idx  = s00_axi_awaddr[ADDR_WIDTH-1:LSB];
    wr_data = s00_axi_wdata;
    wr_strb = s00_axi_wstrb;
    case (wstate_q)
      W_IDLE:    wr_fire = aw_hs & w_hs;
      W_HAVE_AW: begin
        wr_fire = w_hs;
        wr_idx  = aw_idx_q;
      end
      W_HAVE_W:  begin
        wr_fire = aw_hs;
        wr_data = wdata_q;
        wr_strb = wstrb_q;
      end
      default:   wr_fire = 1'b0;
    endcase
  end

  // Out-of-range indices are also >= RW_COUNT, so one compare covers both errors.
  assign wr_ok = (32'(wr_idx) < 32'(RW_COUNT));

  always_comb begin
    wstate_d = wstate_q;
    aw_idx_d = aw_idx_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wstate_d = W_RESP;
        end else if (aw_hs) begin
          aw_idx_d = s00_axi_awaddr[ADDR_WIDTH-1:LSB];
          wstate_d = W_HAVE_AW;
        end else if (w_hs) begin
          wdata_d  = s00_axi_wdata;
          wstrb_d  = s00_axi_wstrb;
          wstate_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_hs)  wstate_d = W_RESP;
      W_HAVE_W:  if (aw_hs) wstate_d = W_RESP;
      W_RESP:    if (s00_axi_bready) wstate_d = W_IDLE;
      default:   wstate_d = W_IDLE;
    endcase
    if (wr_fire) bresp_d = wr_ok ? RESP_OKAY : RESP_SLVERR;
    awready_d = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_W);
    wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_AW);
    bvalid_d  = (wstate_d == W_RESP);
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign wr_pulse_d[gi] = wr_fire && wr_ok && (wr_idx[RIDX_W-1:0] == RIDX_W'(gi));
      if (gi < RW_COUNT) begin : g_rw
        assign rd_word[gi] = regs_q[gi];
        assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
      end else begin : g_ro
        assign rd_word[gi] = status_in[(gi-RW_COUNT)*DATA_WIDTH +: DATA_WIDTH];
        assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_pulse_d[i]) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_strb[b]) regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_idx      = s00_axi_araddr[ADDR_WIDTH-1:LSB];
  assign rd_in_range = (32'(rd_idx) < 32'(NUM_REGS));

  // Read payload is captured at the AR edge and frozen until R completes.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s00_axi_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (rd_in_range) begin
        rdata_d = rd_word[rd_idx[RIDX_W-1:0]];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end
    end
    arready_d = ~rvalid_d;
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wstate_q   <= W_IDLE;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      rvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wstate_q   <= wstate_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      rvalid_q   <= rvalid_d;
      arready_q  <= arready_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = rresp_q;
  assign reg_wr_pulse    = wr_pulse_q;

endmodule

// File: doc/axi_lite_param_regbank.md
Name: axi_lite_param_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; successor to the fixed 4-register CNN memory-mapped slave.
- Generalised in register count and data width; adds byte strobes, read-only status registers, per-register write pulses, and SLVERR decoding.
- Sits between the PS/interconnect AXI4-Lite master port and CNN control/status logic in the PL.

Parameters:
- DATA_WIDTH, 32, AXI data width; allowed values 32 or 64.
- NUM_REGS, 16, total register count; must be a power of 2, 1..256.
- NUM_RO, 4, number of read-only status registers occupying the top indices [NUM_REGS-NUM_RO .. NUM_REGS-1]; 0..NUM_REGS.
- ADDR_WIDTH, 8, AXI address width; must be at least log2(NUM_REGS)+log2(DATA_WIDTH/8).

Ports:
- s00_axi_aclk  in  1  clock.
- s00_axi_aresetn  in  1  asynchronous active-low reset.
- s00_axi_awaddr  in  ADDR_WIDTH  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in / out  1  AW handshake.
- s00_axi_wdata  in  DATA_WIDTH  write data.
- s00_axi_wstrb  in  DATA_WIDTH/8  byte enables.
- s00_axi_wvalid / s00_axi_wready  in / out  1  W handshake.
- s00_axi_bresp  out  2  write response.
- s00_axi_bvalid / s00_axi_bready  out / in  1  B handshake.
- s00_axi_araddr  in  ADDR_WIDTH  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in / out  1  AR handshake.
- s00_axi_rdata  out  DATA_WIDTH  read data.
- s00_axi_rresp  out  2  read response.
- s00_axi_rvalid / s00_axi_rready  out / in  1  R handshake.
- reg_out  out  NUM_REGS*DATA_WIDTH  flattened RW register contents; RO slots read as 0.
- reg_wr_pulse  out  NUM_REGS  one-cycle strobe per successful write.
- status_in  in  NUM_RO*DATA_WIDTH  values for the RO registers.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert): all registers 0; all ready/valid outputs 0; bresp, rresp, rdata, reg_wr_pulse all 0. Reset mid-transaction aborts it; no partial write survives.
- Register index = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]. Byte-offset bits are ignored.
- Write FSM states:
  - W_IDLE: awready=1, wready=1.
  - W_HAVE_AW: AW captured; awready=0, wready=1.
  - W_HAVE_W: W captured; awready=1, wready=0.
  - W_RESP: bvalid=1, both readies 0.
- AW and W are accepted in either order or in the same cycle.
- On the edge at which the second of AW/W completes: the register is updated, reg_wr_pulse[idx]=1 for that one cycle, and bvalid rises. Latency is 1 cycle from the last handshake to bvalid.
- Byte lane b is written only if wstrb[b]=1. wstrb=0 is a successful no-op: OKAY response, pulse still asserted.
- Write error cases, both with no update, no pulse, and bresp=2'b10 (SLVERR):
  - idx >= NUM_REGS.
  - idx falls in the RO range.
- W_RESP holds until bvalid && bready, then returns to W_IDLE. Only one write is outstanding at a time.
- Read path: arready=1 only when rvalid=0.
- On the AR handshake edge, rdata/rresp are registered and rvalid rises. Latency is 1 cycle.
- Read data sources:
  - RW index: returns the register value.
  - RO index: returns the status_in slice sampled at the AR handshake edge.
  - idx >= NUM_REGS: rdata=0, rresp=SLVERR.
- rdata/rresp are held stable while rvalid && !rready.
- Read and write channels are independent and may complete in the same cycle. A same-cycle read of a register being written returns the pre-write value.

Test Plan:
- Reset, then write 0x1,0x2,0x3,0x4 to addresses 0x00..0x0C and read back -> rdata equals the written data, rresp=OKAY, reg_wr_pulse[0..3] each high exactly 1 cycle.
- Preload reg 5=0xFFFFFFFF, write 0x12345678 with wstrb=4'b0101 -> read returns 0xFF34FF78.
- Present W one cycle before AW, then AW before W, then both together, all to reg 2 -> bvalid arrives 1 cycle after the last handshake in every case; final value correct.
- status_in for reg 12 = 0xCAFEBABE (NUM_REGS=16, NUM_RO=4): read 0x30 -> 0xCAFEBABE, OKAY. Write 0x30 -> SLVERR, no pulse, value unchanged.
- Read from 0x40 (idx 16) -> rdata=0, SLVERR. Write 0x40 -> SLVERR, all reg_out unchanged.
- Hold bready=0 and rready=0 for 5 cycles -> bvalid/rvalid and their payloads stay stable, awready/arready stay 0. Assert reset mid-W_HAVE_AW -> all outputs return to 0 immediately.
